// File: rtl/contador_sat.sv
// rtl/contador_sat.sv - parametrised saturating event counter
module contador_sat #(
    parameter int NB_CNT = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_inc,
    output logic [NB_CNT-1:0] o_count
);

    // Count increment requests, sticking at all-ones instead of wrapping
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {NB_CNT{1'b1}})) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/sumador_exponente_pipe.sv
// rtl/sumador_exponente_pipe.sv - two-stage biased exponent adder, optional SUMADOR_EXPONENTE_SAT_EN saturation
module sumador_exponente_pipe #(
    parameter int NB_EXP = 4,
    parameter int BIAS   = 7,
    parameter int NB_CNT = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [NB_EXP-1:0] i_exponente_1,
    input  logic [NB_EXP-1:0] i_exponente_2,
    input  logic              i_norm,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NB_EXP-1:0] o_exponente,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic [NB_CNT-1:0] o_cnt_ovf
);

    // Two extra bits: one for the carry of e1+e2+norm, one for the sign after unbiasing
    localparam int NB_SUM = NB_EXP + 2;
    localparam logic signed [NB_SUM-1:0] BIAS_S = NB_SUM'(BIAS);
    localparam logic signed [NB_SUM-1:0] EXP_MAX_S = NB_SUM'((1 << NB_EXP) - 1);

    logic              s1_valid;
    logic [NB_SUM-1:0] s1_sum;
    logic              s1_zero;

    logic              s2_valid;
    logic [NB_EXP-1:0] s2_exp;
    logic              s2_ovf;
    logic              s2_unf;

    logic              s2_adv;
    logic              s1_adv;
    logic              in_xfer;
    logic              out_xfer;

    logic signed [NB_SUM-1:0] res_c;
    logic                     ovf_c;
    logic                     unf_c;
    logic [NB_EXP-1:0]        exp_c;

    assign s2_adv   = !s2_valid || i_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign o_ready  = !s1_valid || s1_adv;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = s2_valid && i_ready;

    // Unbias the stage-1 sum and classify it; a zero operand forces a clean zero result
    always_comb begin
        res_c = $signed(s1_sum) - BIAS_S;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        exp_c = '0;
        if (!s1_zero) begin
            ovf_c = (res_c > EXP_MAX_S);
            unf_c = res_c[NB_SUM-1];
`ifdef SUMADOR_EXPONENTE_SAT_EN
            if (ovf_c) begin
                exp_c = {NB_EXP{1'b1}};
            end else if (unf_c) begin
                exp_c = '0;
            end else begin
                exp_c = res_c[NB_EXP-1:0];
            end
`else
            exp_c = res_c[NB_EXP-1:0];
`endif
        end
    end

    // Stage 1: capture raw sum of the biased exponents plus normalisation carry
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_sum  <= NB_SUM'(i_exponente_1) + NB_SUM'(i_exponente_2) + NB_SUM'(i_norm);
                s1_zero <= (i_exponente_1 == '0) || (i_exponente_2 == '0);
            end
        end
    end

    // Stage 2: hold the final exponent and flags until the consumer takes them
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_valid <= 1'b0;
            s2_exp   <= '0;
            s2_ovf   <= 1'b0;
            s2_unf   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_exp <= exp_c;
                s2_ovf <= ovf_c;
                s2_unf <= unf_c;
            end
        end
    end

    assign o_valid     = s2_valid;
    assign o_exponente = s2_exp;
    assign o_overflow  = s2_ovf;
    assign o_underflow = s2_unf;

    contador_sat #(
        .NB_CNT (NB_CNT)
    ) u_cnt_ovf (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_inc     (out_xfer && s2_ovf),
        .o_count   (o_cnt_ovf)
    );

endmodule
